// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings, multiplier FSM states and datapath width.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_MUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/ex_mul_unit_if.sv
// EX-stage multiplier bundle: opcode/operands/flush from the pipeline, stall/done/product back.
interface ex_mul_unit_if #(
    parameter int WIDTH = cpu_pkg::WIDTH
) ();

    logic [2:0]       aluop;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output aluop, op_a, op_b, flush,
        input  stall, done, result_hi, result_lo
    );

    modport slave (
        input  aluop, op_a, op_b, flush,
        output stall, done, result_hi, result_lo
    );

endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand register, {acc_hi,acc_lo} accumulator and adder.
module mul_shift_add_dp #(
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             clear,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH:0]   sum_s;

    // Partial-product add, carry kept as the extra top bit
    always_comb begin
        if (acc_lo_r[0]) begin
            sum_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_hi_r};
        end
    end

    // Accumulator: clear wins over load, load over step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            mcand_r  <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= {WIDTH{1'b0}};
        end else if (load) begin
            mcand_r  <= op_a;
            acc_hi_r <= {WIDTH{1'b0}};
            acc_lo_r <= op_b;
        end else if (step) begin
            acc_hi_r <= sum_s[WIDTH:1];
            acc_lo_r <= {sum_s[0], acc_lo_r[WIDTH-1:1]};
        end else begin
            acc_hi_r <= acc_hi_r;
            acc_lo_r <= acc_lo_r;
        end
    end

    assign acc_hi = acc_hi_r;
    assign acc_lo = acc_lo_r;

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage iterative unsigned multiplier: stalls the front-end for WIDTH+1 cycles,
// then presents the 2*WIDTH-bit product with a one-cycle done pulse.
module ex_mul_unit
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ex_mul_unit_if.slave  mul
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t    state_r;
    mul_state_t    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic          done_r;
    logic          is_mul_s;
    logic          launch_s;
    logic          step_s;
    logic          stall_s;

    assign is_mul_s = (mul.aluop == ALUOP_MUL);
    assign launch_s = (state_r == IDLE) && is_mul_s && !mul.flush;
    assign step_s   = (state_r == BUSY) && !mul.flush;

    // Next-state and stall decode; flush beats both launch and completion
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = launch_s;
                if (launch_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (mul.flush) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                stall_s     = 1'b0;
                state_nxt_s = IDLE;
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, iteration counter and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else if (mul.flush) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= step_s && (cnt_r == {CW{1'b0}});
            if (launch_s) begin
                cnt_r <= CW'(WIDTH - 1);
            end else if (step_s && (cnt_r != {CW{1'b0}})) begin
                cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (launch_s),
        .step   (step_s),
        .clear  (mul.flush),
        .op_a   (mul.op_a),
        .op_b   (mul.op_b),
        .acc_hi (mul.result_hi),
        .acc_lo (mul.result_lo)
    );

    // Stall must read 0 while reset is held even if the opcode is MUL
    assign mul.stall = rst && stall_s;
    assign mul.done  = done_r;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: product vector table with a scoreboard,
// plus back-to-back, flush, async reset and non-MUL opcode sequences.
module tb_ex_mul_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ex_mul_unit_if #(.WIDTH(WIDTH)) mif ();

    ex_mul_unit dut (
        .clk (clk),
        .rst (rst),
        .mul (mif)
    );

    always #5 clk = ~clk;

    vec_t sb_q[$];
    vec_t vecs[8];
    vec_t exp_v;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest launched multiply
    always @(negedge clk) begin
        if (rst && mif.done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending multiply");
            end else begin
                exp_v = sb_q.pop_front();
                check("product", {mif.result_hi, mif.result_lo}, {exp_v.hi, exp_v.lo});
            end
        end
    end

    task automatic do_mul(input vec_t v, input string tag);
        int lat;
        int busy_stall;
        @(negedge clk);
        mif.aluop = ALUOP_MUL;
        mif.op_a  = v.a;
        mif.op_b  = v.b;
        sb_q.push_back(v);
        #1;
        check({tag, " launch_stall"}, 64'(mif.stall), 64'd1);
        lat        = 0;
        busy_stall = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mif.done) begin
                lat = i;
                break;
            end
            if (mif.stall) busy_stall++;
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy_stall"}, 64'(busy_stall), 64'd32);
        check({tag, " done_stall"}, 64'(mif.stall), 64'd0);
    endtask

    task automatic go_idle(input vec_t v, input string tag);
        @(negedge clk);
        mif.aluop = ALUOP_ADD;
        #1;
        check({tag, " idle_stall"}, 64'(mif.stall), 64'd0);
        check({tag, " idle_done"}, 64'(mif.done), 64'd0);
        check({tag, " held_result"}, {mif.result_hi, mif.result_lo}, {v.hi, v.lo});
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        int   done_seen;

        vecs[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'd0,          32'hDEAD_BEEF,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'hDEAD_BEEF,  32'd1,          32'h0000_0000, 32'hDEAD_BEEF};
        vecs[4] = '{32'hFFFF_FFFF,  32'd2,          32'h0000_0001, 32'hFFFF_FFFE};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{32'h0001_0000,  32'h0000_FFFF,  32'h0000_0000, 32'hFFFF_0000};
        vecs[7] = '{32'd1,          32'hFFFF_FFFF,  32'h0000_0000, 32'hFFFF_FFFF};

        // Reset state, with a MUL opcode present while reset is held
        mif.aluop = ALUOP_MUL;
        mif.op_a  = 32'd3;
        mif.op_b  = 32'd5;
        mif.flush = 1'b0;
        #12;
        check("rst_stall", 64'(mif.stall), 64'd0);
        check("rst_done", 64'(mif.done), 64'd0);
        check("rst_result", {mif.result_hi, mif.result_lo}, 64'd0);
        mif.aluop = ALUOP_ADD;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 64'(mif.stall), 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i], $sformatf("vec%0d", i));
            go_idle(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: second launch in the cycle right after DONE
        v1 = '{32'd7, 32'd9, 32'h0000_0000, 32'h0000_003F};
        v2 = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        do_mul(v1, "b2b_first");
        do_mul(v2, "b2b_second");

        // Non-MUL opcode keeps everything quiet and the product held
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mif.aluop = ALUOP_AND;
            #1;
            check("nonmul_stall", 64'(mif.stall), 64'd0);
            check("nonmul_done", 64'(mif.done), 64'd0);
            check("nonmul_result", {mif.result_hi, mif.result_lo}, 64'h0000_0001_0000_0000);
        end

        // Flush in the middle of an operation
        @(negedge clk);
        mif.aluop = ALUOP_MUL;
        mif.op_a  = 32'd3;
        mif.op_b  = 32'd5;
        sb_q.push_back(vecs[0]);
        repeat (10) @(negedge clk);
        check("flush_busy_stall", 64'(mif.stall), 64'd1);
        mif.flush = 1'b1;
        sb_q.delete();
        @(negedge clk);
        mif.flush = 1'b0;
        mif.aluop = ALUOP_ADD;
        #1;
        check("flush_stall", 64'(mif.stall), 64'd0);
        check("flush_done", 64'(mif.done), 64'd0);
        check("flush_result", {mif.result_hi, mif.result_lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.done) done_seen = 1;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);

        // Flush in IDLE with a MUL opcode suppresses the launch
        @(negedge clk);
        mif.aluop = ALUOP_MUL;
        mif.flush = 1'b1;
        #1;
        check("idle_flush_stall", 64'(mif.stall), 64'd0);
        @(negedge clk);
        mif.flush = 1'b0;
        mif.aluop = ALUOP_ADD;
        #1;
        check("idle_flush_nolaunch", 64'(mif.stall), 64'd0);

        // Flush coinciding with DONE: done holds this cycle, clears next
        do_mul(vecs[4], "flush_done");
        mif.flush = 1'b1;
        #1;
        check("flushdone_done_held", 64'(mif.done), 64'd1);
        @(negedge clk);
        mif.flush = 1'b0;
        mif.aluop = ALUOP_ADD;
        #1;
        check("flushdone_done_clr", 64'(mif.done), 64'd0);
        check("flushdone_stall", 64'(mif.stall), 64'd0);
        check("flushdone_result", {mif.result_hi, mif.result_lo}, 64'd0);

        // Asynchronous reset mid-operation, between clock edges
        @(negedge clk);
        mif.aluop = ALUOP_MUL;
        mif.op_a  = 32'hFFFF_FFFF;
        mif.op_b  = 32'hFFFF_FFFF;
        sb_q.push_back(vecs[1]);
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_stall", 64'(mif.stall), 64'd0);
        check("async_rst_done", 64'(mif.done), 64'd0);
        check("async_rst_result", {mif.result_hi, mif.result_lo}, 64'd0);
        @(negedge clk);
        mif.aluop = ALUOP_ADD;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release_stall", 64'(mif.stall), 64'd0);
        check("rst_release_done", 64'(mif.done), 64'd0);
        check("rst_release_result", {mif.result_hi, mif.result_lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
